alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal: 8, 16, 32, 64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  the operand set is presented.
REQ-006 SHALL have port in_ready  output  1  the block accepts an operand set this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B; b[SHW-1:0] is the shift amount.
REQ-009 SHALL have port op  input  4  operation code (alu_pkg::alu_op_t).
REQ-010 SHALL have port out_valid  output  1  result and flags are valid.
REQ-011 SHALL have port out_ready  input  1  the consumer takes the result this cycle.
REQ-012 SHALL have port result  output  WIDTH  registered result.
REQ-013 SHALL have port flags  output  4  {neg, ovf, carry, zero}, registered.
REQ-014 SHALL have port err  output  1  illegal opcode; qualified by out_valid.

Function
REQ-015 SHALL implement these opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 0/1), 9 SLTU, 10 MUL (low WIDTH bits of the product).
REQ-016 Opcodes 11-15 SHALL produce result=0, flags=0001 and err=1; they complete as a single-cycle op.
REQ-017 Handshakes SHALL take place only on valid&&ready; in_valid, a, b and op are sampled only at input acceptance.
REQ-018 FSM states SHALL be IDLE, BUSY and HOLD; the reset state is IDLE.
REQ-019 In IDLE, in_ready SHALL be 1. Acceptance of a non-MUL op goes to HOLD with result registered (latency 1 cycle). Acceptance of MUL goes to BUSY.
REQ-020 In BUSY, in_ready SHALL be 0; the multiplier iterates WIDTH cycles, then the FSM goes to HOLD (MUL latency WIDTH+1 cycles from acceptance to out_valid).
REQ-021 In HOLD, out_valid SHALL be 1 and result/flags/err stay stable until out_ready.
REQ-022 In HOLD, in_ready SHALL equal out_ready, so an output drain and a new acceptance in the same cycle give back-to-back single-cycle ops at full throughput.
REQ-023 In HOLD, out_ready&&!in_valid SHALL return the FSM to IDLE.
REQ-024 Flag zero SHALL be 1 when result==0, and neg SHALL be result[WIDTH-1].
REQ-025 Flags carry/ovf SHALL be valid for ADD/SUB only (carry = carry out for ADD, borrow-not for SUB; ovf = signed overflow) and SHALL be 0 for all other ops.
REQ-026 Shifts SHALL use only b[SHW-1:0]; a shift amount of 0 returns a unchanged; SRA replicates a[WIDTH-1].
REQ-027 Arithmetic SHALL wrap modulo 2^WIDTH, with no saturation.
REQ-028 A change on a, b or op while the FSM is not accepting SHALL have no effect.

Reset
REQ-029 With rst_n low, the FSM SHALL be IDLE and the outputs SHALL be result=0, flags=0, err=0, out_valid=0, in_ready=0; in_ready rises in the first clk cycle after deassertion.
REQ-030 Reset asserted in BUSY or HOLD SHALL abort the operation immediately; the pending result is discarded and never presented.

Configuration
REQ-031 The macro SHALL be ALU_PIPE_MUL_EN. When defined, MUL behaves per REQ-019/REQ-020.
REQ-032 When ALU_PIPE_MUL_EN is undefined, opcode 10 SHALL be treated as illegal per REQ-016, BUSY SHALL be unreachable, and no multiplier logic SHALL be instantiated.

Structure
REQ-033 Package alu_pkg SHALL hold alu_op_t (4-bit enum), alu_state_t (IDLE/BUSY/HOLD), and flag bit-index constants.
REQ-034 Sub-module alu_mul_seq SHALL implement the shift-add multiplier.
REQ-035 alu_mul_seq ports SHALL be start, a, b, done and product[WIDTH-1:0], on the same clk/rst_n; it is instantiated only under ALU_PIPE_MUL_EN.

Verification (WIDTH=32 unless stated)
REQ-036 ADD a=FFFFFFFF, b=00000001 -> result 0, flags 0011 (carry, zero), 1 cycle later.
REQ-037 SUB a=80000000, b=00000001 -> result 7FFFFFFF, ovf=1, neg=0; SRA a=80000000, b=0000001F -> FFFFFFFF; SLT a=FFFFFFFF, b=0 -> 1; SLTU with the same operands -> 0.
REQ-038 Back-to-back ADDs with out_ready held high -> one result per cycle, with no bubbles and in_ready continuously 1.
REQ-039 MUL a=0000FFFF, b=00010001 with ALU_PIPE_MUL_EN -> result FFFFFFFF after 33 cycles, in_ready=0 throughout BUSY. Without the macro, the same stimulus -> err=1, result 0, after 1 cycle.
REQ-040 out_ready held low for 5 cycles in HOLD -> result/flags stable and in_ready=0. Then rst_n pulsed low mid-MUL -> out_valid=0 immediately, and no stale result appears after reset.
REQ-041 op=1111 -> err=1, result 0, flags 0001; WIDTH=8 ADD 7F+01 -> result 80, ovf=1, neg=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the alu_pipe block: opcodes, FSM states, flag bit positions.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } alu_state_t;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_NEG   = 3;

    function automatic logic [3:0] pack_flags(input logic neg, input logic ovf,
                                              input logic carry, input logic zero);
        logic [3:0] f;
        f             = '0;
        f[FLAG_NEG]   = neg;
        f[FLAG_OVF]   = ovf;
        f[FLAG_CARRY] = carry;
        f[FLAG_ZERO]  = zero;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per start.
// product/done are combinational so the final iteration can be captured on the same edge.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= CW'(WIDTH);
        end else if (cnt != '0) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end

    // Value of the accumulator after the iteration running this cycle.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = (cnt == CW'(1));

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags; IDLE/BUSY/HOLD control.
// Define ALU_PIPE_MUL_EN to enable the sequential multiplier (opcode MUL); otherwise MUL is illegal.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);

    localparam int MSB = WIDTH - 1;

    alu_state_t       state, state_next;
    alu_op_t          op_e;
    logic             started;
    logic             accept;
    logic             is_mul;
    logic             illegal;
    logic             mul_done;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [SHW-1:0]   shamt;

    assign op_e   = alu_op_t'(op);
    assign shamt  = b[SHW-1:0];
    assign accept = in_valid && in_ready;

    always_comb begin
        sum_ext   = {1'b0, a} + {1'b0, b};
        diff_ext  = {1'b0, a} - {1'b0, b};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        illegal   = 1'b0;
        case (op_e)
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_carry = ~diff_ext[WIDTH];
                alu_ovf   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_PIPE_MUL_EN
            OP_MUL:  alu_res = '0;
`endif
            default: illegal = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    logic             mul_start;
    logic [WIDTH-1:0] mul_product;

    assign is_mul    = (op_e == OP_MUL);
    assign mul_start = accept && is_mul;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
`endif

    // started holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            started <= 1'b0;
        end else begin
            state   <= state_next;
            started <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = is_mul ? BUSY : HOLD;
            BUSY: if (mul_done) state_next = HOLD;
            HOLD: begin
                if (accept)         state_next = is_mul ? BUSY : HOLD;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: in_ready = started;
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            flags  <= '0;
            err    <= 1'b0;
        end else if (accept && !is_mul) begin
            result <= alu_res;
            flags  <= pack_flags(alu_res[MSB], alu_ovf, alu_carry, (alu_res == '0));
            err    <= illegal;
        end
`ifdef ALU_PIPE_MUL_EN
        else if (mul_done) begin
            result <= mul_product;
            flags  <= pack_flags(mul_product[MSB], 1'b0, 1'b0, (mul_product == '0));
            err    <= 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe against an arithmetic reference model; follows ALU_PIPE_MUL_EN.
module tb_alu_pipe;

    localparam int W = 32;
`ifdef ALU_PIPE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, err;
    logic [W-1:0] a, b, result;
    logic [3:0]   op, flags;

    logic         in_valid8, in_ready8, out_valid8, out_ready8, err8;
    logic [7:0]   a8, b8, result8;
    logic [3:0]   op8, flags8;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .err(err)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .flags(flags8), .err(err8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: operands held as plain integers, signed view by subtracting 2^w.
    function automatic void model(input int w, input logic [3:0] o,
                                  input longint unsigned x, input longint unsigned y,
                                  output longint unsigned r, output logic [3:0] f,
                                  output logic e);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint          sx   = ((x >> (w - 1)) & 1) != 0 ? longint'(x) - (longint'(1) << w) : longint'(x);
        longint          sy   = ((y >> (w - 1)) & 1) != 0 ? longint'(y) - (longint'(1) << w) : longint'(y);
        longint          smax = (longint'(1) << (w - 1)) - 1;
        longint          smin = -(longint'(1) << (w - 1));
        longint          s;
        int              sh   = int'(y % longint'(w));
        logic            c = 1'b0, v = 1'b0;
        e = 1'b0;
        r = 0;
        case (o)
            4'd0: begin r = (x + y) & mask; c = ((x + y) >> w) != 0; s = sx + sy; v = (s > smax) || (s < smin); end
            4'd1: begin r = (x - y) & mask; c = (x >= y); s = sx - sy; v = (s > smax) || (s < smin); end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = (x << sh) & mask;
            4'd6: r = x >> sh;
            4'd7: r = longint'(sx >>> sh) & mask;
            4'd8: r = (sx < sy) ? 1 : 0;
            4'd9: r = (x < y) ? 1 : 0;
            4'd10: begin r = (x * y) & mask; e = !MUL_EN; end
            default: e = 1'b1;
        endcase
        if (e) begin
            r = 0;
            f = 4'b0001;
        end else begin
            f = {((r >> (w - 1)) & 1) != 0, v, c, r == 0};
        end
    endfunction

    // One transaction: accept, wait for HOLD (bounded), check, hold, drain.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] ra, input logic [W-1:0] rb,
                          input int hold);
        longint unsigned er;
        logic [3:0]      ef;
        logic            ee;
        int              lat;
        int              elat;
        model(W, o, 64'(ra), 64'(rb), er, ef, ee);
        elat = (MUL_EN && o == 4'd10) ? W + 1 : 1;
        @(negedge clk);
        a = ra; b = rb; op = o; in_valid = 1'b1; out_ready = 1'b0;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        // Offered but must not be accepted while busy or holding.
        a = $urandom; b = $urandom; op = 4'($urandom);
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 3 * W) begin
            chk("in_ready_busy", 64'(in_ready), 64'd0);
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(elat));
        chk("result", 64'(result), er);
        chk("flags", 64'(flags), 64'(ef));
        chk("err", 64'(err), 64'(ee));
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_result", 64'(result), er);
            chk("hold_flags", 64'(flags), 64'(ef));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("drain", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0]     bexp [8];
        longint unsigned r8;
        logic [3:0]      f8, fd;
        logic            e8, ed;
        logic [3:0]      o;
        logic [W-1:0]    ra, rb;
        int              seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_release", 64'(in_ready), 64'd1);

        // Directed corner cases.
        run_op(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1);
        run_op(4'd1, 32'h8000_0000, 32'h0000_0001, 1);
        run_op(4'd7, 32'h8000_0000, 32'h0000_001F, 1);
        run_op(4'd8, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op(4'd9, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 1);
        run_op(4'd5, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 1);
        run_op(4'd7, 32'h8765_4321, 32'h0000_0020, 1);
        run_op(4'd10, 32'h0000_FFFF, 32'h0001_0001, 1);
        run_op(4'd3, 32'hA5A5_0000, 32'h0000_5A5A, 5);

        for (int i = 0; i < 40; i++) begin
            o  = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = (i % 3 == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
            run_op(o, ra, rb, 1);
        end

        // Back-to-back ADDs with out_ready held high.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ra = $urandom; rb = $urandom;
            model(W, 4'd0, 64'(ra), 64'(rb), bexp[i], fd, ed);
            a = ra; b = rb; op = 4'd0; in_valid = 1'b1; out_ready = 1'b1;
            chk("b2b_in_ready", 64'(in_ready), 64'd1);
            if (i > 0) begin
                chk("b2b_valid", 64'(out_valid), 64'd1);
                chk("b2b_result", 64'(result), bexp[i-1]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_last_valid", 64'(out_valid), 64'd1);
        chk("b2b_last_result", 64'(result), bexp[7]);
        @(negedge clk);
        chk("b2b_drain", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Reset in the middle of a MUL (or in HOLD when MUL is illegal).
        @(negedge clk);
        a = 32'h0000_FFFF; b = 32'h0001_0001; op = 4'd10; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_flags", 64'(flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < W + 5; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_stale_result", 64'(seen), 64'd0);
        chk("ready_after_abort", 64'(in_ready), 64'd1);

        // Narrow instance: signed overflow into the sign bit.
        @(negedge clk);
        a8 = 8'h7F; b8 = 8'h01; op8 = 4'd0; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        chk("w8_valid", 64'(out_valid8), 64'd1);
        chk("w8_result", 64'(result8), 64'h80);
        chk("w8_flags", 64'(flags8), 64'b1100);
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        a8 = 8'h80; b8 = 8'h01; op8 = 4'd1; in_valid8 = 1'b1;
        model(8, 4'd1, 64'h80, 64'h01, r8, f8, e8);
        @(negedge clk);
        in_valid8 = 1'b0;
        chk("w8_sub_result", 64'(result8), r8);
        chk("w8_sub_flags", 64'(flags8), 64'(f8));
        chk("w8_sub_err", 64'(err8), 64'(e8));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
